// File: rtl/lm70_pkg.sv
// Shared types and constants for the LM70 SPI responder: FSM states, frame sizes and command codes.
package lm70_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lm70_state_e;

  localparam int          READ_BITS    = 16;
  localparam int          WRITE_BITS   = 16;
  localparam logic [15:0] SHUTDOWN_ID  = 16'h8100;
  localparam logic [4:0]  STATUS_TAIL  = 5'b11111;
  localparam logic [7:0]  CMD_SHUTDOWN = 8'hFF;
  localparam logic [7:0]  CMD_RUN      = 8'h00;

  // Word presented to the master: device ID in shutdown, otherwise temperature plus status tail.
  function automatic logic [15:0] frame_word(input logic sd, input logic [10:0] temp);
    frame_word = sd ? SHUTDOWN_ID : {temp, STATUS_TAIL};
  endfunction

endpackage

// File: rtl/lm70_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI line, with rise/fall pulses on the synchronized copy.
module lm70_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign q    = sync_r[SYNC_STAGES-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;

endmodule

// File: rtl/lm70_spi_responder.sv
// LM70 temperature-sensor emulator on the single-wire SI/O bus: 16-bit read frame, then 16-bit command.
// Define LM70_RESP_RAMP_EN to replace temp_in with an internal temperature ramp.
module lm70_spi_responder
  import lm70_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [10:0] RAMP_STEP   = 11'd4,
  parameter logic [10:0] RAMP_MAX    = 11'd400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        sio_in,
  output logic        sio_out,
  output logic        sio_oe,
  input  logic [10:0] temp_in,
  output logic        shutdown,
  output logic        frame_done
);

  localparam logic [4:0] RD_LAST = 5'(READ_BITS - 1);
  localparam logic [4:0] WR_LAST = 5'(WRITE_BITS - 1);

  lm70_state_e            state_r;
  logic [15:0]            shift_r;
  logic [15:0]            cmd_r;
  logic [4:0]             cnt_r;
  logic [SYNC_STAGES-1:0] sio_sync_r;

  logic        unused_cs_level_s, unused_sck_level_s;
  logic        cs_rise_s, cs_fall_s, sck_rise_s, sck_fall_s;
  logic        sio_s, cs_evt_s, read_last_s;
  logic [15:0] cmd_next_s, frame_word_s;
  logic [10:0] temp_src_s;

  lm70_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk (clk), .rst_n (rst_n), .d (cs_n),
    .q (unused_cs_level_s), .rise (cs_rise_s), .fall (cs_fall_s)
  );

  lm70_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk (clk), .rst_n (rst_n), .d (sck),
    .q (unused_sck_level_s), .rise (sck_rise_s), .fall (sck_fall_s)
  );

  // Level-only synchronizer for the command data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sio_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sio_sync_r <= {sio_sync_r[SYNC_STAGES-2:0], sio_in};
    end
  end

  assign sio_s        = sio_sync_r[SYNC_STAGES-1];
  assign cs_evt_s     = cs_rise_s | cs_fall_s;
  assign read_last_s  = (state_r == READ) && !cs_evt_s && sck_rise_s && (cnt_r == RD_LAST);
  assign cmd_next_s   = {cmd_r[14:0], sio_s};
  assign frame_word_s = frame_word(shutdown, temp_src_s);

`ifdef LM70_RESP_RAMP_EN
  logic [10:0] ramp_r;
  logic [11:0] ramp_sum_s;
  logic        unused_temp_in_s;

  assign ramp_sum_s       = {1'b0, ramp_r} + {1'b0, RAMP_STEP};
  assign temp_src_s       = ramp_r;
  assign unused_temp_in_s = ^temp_in;

  // Ramp advances once per completed read frame; frozen while the ID is being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_r <= 11'd0;
    end else if (read_last_s && !shutdown) begin
      ramp_r <= (ramp_sum_s > {1'b0, RAMP_MAX}) ? 11'd0 : ramp_sum_s[10:0];
    end
  end
`else
  logic unused_ramp_cfg_s;

  assign temp_src_s        = temp_in;
  assign unused_ramp_cfg_s = ^{RAMP_STEP, RAMP_MAX};
`endif

  // Frame FSM; chip-select edges take priority over any SCK edge in the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= 16'h0000;
      cmd_r      <= 16'h0000;
      cnt_r      <= 5'd0;
      sio_out    <= 1'b0;
      sio_oe     <= 1'b0;
      shutdown   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_rise_s) begin
        state_r <= IDLE;
        sio_oe  <= 1'b0;
        cnt_r   <= 5'd0;
      end else if (cs_fall_s) begin
        state_r <= READ;
        shift_r <= frame_word_s;
        sio_out <= frame_word_s[15];
        sio_oe  <= 1'b1;
        cnt_r   <= 5'd0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          READ: begin
            if (sck_fall_s) begin
              shift_r <= {shift_r[14:0], 1'b0};
              sio_out <= shift_r[14];
            end
            if (read_last_s) begin
              cnt_r      <= 5'd0;
              frame_done <= 1'b1;
              sio_oe     <= 1'b0;
              state_r    <= WRITE;
            end else if (sck_rise_s) begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
          WRITE: begin
            if (sck_rise_s) begin
              cmd_r <= cmd_next_s;
              if (cnt_r == WR_LAST) begin
                cnt_r   <= 5'd0;
                state_r <= DONE;
                if (cmd_next_s[7:0] == CMD_SHUTDOWN) begin
                  shutdown <= 1'b1;
                end else if (cmd_next_s[7:0] == CMD_RUN) begin
                  shutdown <= 1'b0;
                end
              end else begin
                cnt_r <= cnt_r + 5'd1;
              end
            end
          end
          DONE: begin
            sio_oe <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            sio_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
